// File: rtl/packet_timer.sv
// Bit-period and packet-length timer: one-cycle shift_strobe every CLKS_PER_BIT
// enabled clocks, with packet_done on every BITS_PER_PACKET-th strobe.
module packet_timer #(
  parameter int CLKS_PER_BIT    = 10,
  parameter int BITS_PER_PACKET = 9
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable_timer,
  output logic shift_strobe,
  output logic packet_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (BITS_PER_PACKET > 1) ? $clog2(BITS_PER_PACKET) : 1;
  localparam logic [CW-1:0] CLK_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(BITS_PER_PACKET - 1);

  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt;
  logic          wrap_c;
  logic          wrap_b;

  assign wrap_c = enable_timer && (clk_cnt == CLK_MAX);
  assign wrap_b = wrap_c && (bit_cnt == BIT_MAX);

  // n_rst is active high despite its name; enable low also clears state.
  always_ff @(posedge clk) begin
    if (n_rst || !enable_timer) begin
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shift_strobe <= 1'b0;
      packet_done  <= 1'b0;
    end else begin
      clk_cnt      <= wrap_c ? '0 : clk_cnt + 1'b1;
      bit_cnt      <= wrap_b ? '0 : (wrap_c ? bit_cnt + 1'b1 : bit_cnt);
      shift_strobe <= wrap_c;
      packet_done  <= wrap_b;
    end
  end
endmodule

// File: tb/tb_packet_timer.sv
// Scoreboard bench for packet_timer: default build and a CLKS_PER_BIT=2,
// BITS_PER_PACKET=1 build share stimulus; a run-length model predicts outputs.
module tb_packet_timer;
  localparam int CA = 10, BA = 9;
  localparam int CB = 2,  BB = 1;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic enable_timer = 1'b0;
  logic strobe_a, done_a, strobe_b, done_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  int run_len = 0;

  always #5 clk = ~clk;

  packet_timer #(.CLKS_PER_BIT(CA), .BITS_PER_PACKET(BA)) dut_a (
    .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer),
    .shift_strobe(strobe_a), .packet_done(done_a));

  packet_timer #(.CLKS_PER_BIT(CB), .BITS_PER_PACKET(BB)) dut_b (
    .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer),
    .shift_strobe(strobe_b), .packet_done(done_b));

  // Model: count consecutive enabled edges since the last reset/disable;
  // a strobe lands on every multiple of C, packet_done on every multiple of C*B.
  always @(posedge clk) begin
    if (n_rst || !enable_timer) begin
      run_len = 0;
      q_a.push_back(2'b00);
      q_b.push_back(2'b00);
    end else begin
      run_len = run_len + 1;
      q_a.push_back({(run_len % (CA * BA)) == 0, (run_len % CA) == 0});
      q_b.push_back({(run_len % (CB * BB)) == 0, (run_len % CB) == 0});
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      n_cmp++;
      if ({done_a, strobe_a} !== e) begin
        n_err++;
        $display("FAIL dflt t=%0t run=%0d got done/strobe=%b%b want %b", $time, run_len, done_a, strobe_a, e);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      n_cmp++;
      if ({done_b, strobe_b} !== e) begin
        n_err++;
        $display("FAIL c2b1 t=%0t run=%0d got done/strobe=%b%b want %b", $time, run_len, done_b, strobe_b, e);
      end
    end
  end

  task automatic step(input logic rst, input logic en, input int n);
    for (int i = 0; i < n; i++) begin
      n_rst = rst;
      enable_timer = en;
      @(negedge clk);
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 2);    // reset
    step(1'b0, 1'b0, 10);   // idle after release
    step(1'b0, 1'b1, 200);  // strobes every 10, done at 90 and 180
    step(1'b0, 1'b0, 2);
    step(1'b0, 1'b1, 45);   // partial packet then drop
    step(1'b0, 1'b0, 3);
    step(1'b0, 1'b1, 100);  // restart from zero
    step(1'b0, 1'b1, 200);
    step(1'b1, 1'b1, 50);   // mid-operation reset with enable held
    step(1'b0, 1'b1, 100);
    for (int i = 0; i < 3000; i++) begin
      n_rst = ($urandom_range(0, 199) == 0);
      enable_timer = ($urandom_range(0, 31) != 0);
      @(negedge clk);
    end
    step(1'b0, 1'b1, 5);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/packet_timer.md
Name: packet_timer

Overview:
Bit-period and packet-length timer for a serial shift datapath. While enabled, it emits a one-cycle shift_strobe once every CLKS_PER_BIT clocks. It also emits a one-cycle packet_done coincident with every BITS_PER_PACKET-th strobe. It sits beside the shift register and controller FSM; the controller drives enable_timer and consumes both pulses.

Parameters:
CLKS_PER_BIT, 10, clock cycles per bit period (>= 2)
BITS_PER_PACKET, 9, strobes per packet (>= 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
n_rst  input  1  synchronous, active-high reset (port name kept per codebase; polarity is high = reset)
enable_timer  input  1  level enable; high = count, low = hold counters cleared
shift_strobe  output  1  registered one-cycle pulse at the end of each bit period
packet_done  output  1  registered one-cycle pulse on the final strobe of a packet

Behaviour:
- Internal clk_cnt, range 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
- Internal bit_cnt, range 0..BITS_PER_PACKET-1, width max(1, $clog2(BITS_PER_PACKET)).
- Define wrap_c = enable_timer && (clk_cnt == CLKS_PER_BIT-1).
- Define wrap_b = wrap_c && (bit_cnt == BITS_PER_PACKET-1).
- Priority at each rising edge: n_rst, then enable_timer, then counting.
- n_rst=1 at an edge: clk_cnt=0, bit_cnt=0, shift_strobe=0, packet_done=0. This overrides everything, including mid-packet.
- n_rst=0, enable_timer=0: clk_cnt<=0, bit_cnt<=0, shift_strobe<=0, packet_done<=0. Dropping enable aborts a partial packet; no pulse is emitted.
- n_rst=0, enable_timer=1:
  - clk_cnt <= wrap_c ? 0 : clk_cnt+1.
  - bit_cnt <= wrap_b ? 0 : (wrap_c ? bit_cnt+1 : bit_cnt).
  - shift_strobe <= wrap_c.
  - packet_done <= wrap_b.
- Latency: the first strobe is high during the cycle following the CLKS_PER_BIT-th consecutive enabled edge. Subsequent strobes follow with period exactly CLKS_PER_BIT. Each strobe is exactly one cycle wide.
- packet_done is high in the same cycle as the BITS_PER_PACKET-th strobe, never otherwise. It is one cycle wide.
- Free-running: with enable held high, packets repeat back-to-back with no gap. The next packet's first strobe comes CLKS_PER_BIT cycles after packet_done.
- Re-enable after low, or release of reset with enable high: counting restarts from zero, so timing is identical to a first enable.
- Wrap-around: counters never exceed their maximum. No overflow state exists.
- BITS_PER_PACKET=1: packet_done accompanies every strobe.
- Outputs are pure flops: glitch-free, with no combinational path from inputs.

Test Plan:
- Reset: hold n_rst=1 for 2 edges with enable_timer=0/X -> shift_strobe=0, packet_done=0 after the first edge; both stay 0 for 10 cycles after release while enable_timer=0.
- Bit period (defaults): raise enable_timer at a negedge -> shift_strobe high for exactly 1 cycle after edge 10, then after edges 20, 30, ... (period 10 clocks, width 1).
- Packet: continue enable -> packet_done high only with the 9th strobe (after edge 90), then again after edge 180. Zero packet_done pulses on strobes 1-8 and 10-17.
- Enable drop: deassert enable_timer after edge 45 for 3 cycles, then reassert -> no pulses while low; first strobe 10 edges after reassert; packet_done on the 9th strobe after reassert.
- Mid-operation reset: enable high for 2000 ns (200 cycles at 10 ns), assert n_rst for 500 ns, release with enable still high -> outputs 0 throughout reset; first strobe 10 edges after release, packet_done 90 edges after release.
- Parameter corner: CLKS_PER_BIT=2, BITS_PER_PACKET=1 -> shift_strobe and packet_done both toggle 0/1 every other cycle, always coincident.
